inst_fifo_packer: RTL
=====================

// Module: inst_fifo_packer
// PURPOSE
//   Instruction FIFO feeding the timing controller. Accepts 32-bit bus writes, pairs them
//   into 64-bit instruction entries and presents them on a first-word-fall-through (FWFT)
//   read port matching the controller's inst_fifo_* interface. Provides fill status used
//   for the hold/release logic, plus sticky overflow detection on the write side.
// PARAMETERS
//   DEPTH_LOG2          9   log2 of entry count (entries are 64 bits; 512 by default)
//   ALMOST_FULL_MARGIN  16  almost_full when count >= 2**DEPTH_LOG2 - ALMOST_FULL_MARGIN
//   ALMOST_EMPTY_THRESH 1   almost_empty when count <= ALMOST_EMPTY_THRESH
// PORTS
//   clock           in   1             system clock, all logic on rising edge
//   resetn          in   1             asynchronous, active-low reset
//   wr_data         in   32            bus write word
//   wr_en           in   1             write strobe, one word per cycle
//   flush           in   1             synchronous clear of contents and pending half
//   clear_overflow  in   1             synchronous clear of overflow flag
//   rd_en           in   1             pop request; ignored when empty
//   rd_data         out  64            head entry; valid whenever empty == 0
//   empty           out  1             no complete entry stored
//   almost_empty    out  1             see ALMOST_EMPTY_THRESH
//   full            out  1             count == 2**DEPTH_LOG2
//   almost_full     out  1             see ALMOST_FULL_MARGIN
//   half_pending    out  1             first word of a pair held, awaiting second
//   count           out  DEPTH_LOG2+1  number of complete entries stored
//   overflow        out  1             sticky: a pair was dropped because FIFO was full
// BEHAVIOUR
// - Reset (resetn low, async): pointers, count = 0, empty = 1, almost_empty = 1, full = 0,
//   almost_full = 0, half_pending = 0, overflow = 0, held word = 0. rd_data unspecified.
// - Packing: first wr_en stores wr_data into hold register, half_pending <= 1. Second wr_en
//   commits {held_word, wr_data} (first word in [63:32]) and clears half_pending. Controller
//   re-swaps halves, so first-written word is the low instruction word.
// - Commit when full (after same-cycle pop considered): pair dropped, overflow <= 1,
//   half_pending <= 0, count/pointers unchanged. Overflow stays 1 until clear_overflow or reset.
// - Storage: 2**DEPTH_LOG2 x 64 array, rd_data read combinationally at read pointer (FWFT).
// - Latency: entry committed on edge N -> empty = 0, rd_data valid after edge N (same cycle
//   as updated count). rd_en & ~empty on edge M pops; next entry visible after edge M.
// - rd_en while empty: no effect, no error (controller asserts rd_en independently of empty).
// - Simultaneous commit and pop: both occur, count unchanged; allowed even when full
//   (pop frees the slot, commit is not an overflow). Pop of the only entry with simultaneous
//   commit: empty stays 0, rd_data shows the new entry.
// - Pointers wrap modulo 2**DEPTH_LOG2; count is authoritative for full/empty.
// - All status outputs are registered, derived from next-state count.
// - flush: highest priority; count = 0, pointers = 0, half_pending = 0, concurrent wr_en and
//   rd_en ignored that cycle; overflow untouched. clear_overflow with a same-cycle dropped
//   pair: overflow ends at 1 (set wins).
// - Reset mid-pair or mid-read discards everything; no partial entry survives.
// TESTING
// - Reset, write 0x11111111 then 0x22222222 -> next cycle empty=0, count=1,
//   rd_data=0x11111111_22222222; single write only -> half_pending=1, empty=1.
// - Fill 512 pairs -> full=1, almost_full asserted at count 496; 513th pair -> overflow=1,
//   count=512, head unchanged; clear_overflow -> overflow=0.
// - Full FIFO, commit and rd_en same cycle -> count stays 512, overflow=0, new entry at tail.
// - rd_en held high while empty for 10 cycles, then one pair written -> entry popped the
//   cycle after it appears; count returns to 0, no spurious pops.
// - Write first half, assert flush -> half_pending=0; next two writes form a clean entry.
// - Pulse resetn low mid-sequence with count=7 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/inst_fifo_packer.sv
// Instruction FIFO: packs pairs of 32-bit bus writes into 64-bit entries and
// presents them on a first-word-fall-through read port with registered fill status.
module inst_fifo_packer #(
  parameter int unsigned DEPTH_LOG2          = 9,
  parameter int unsigned ALMOST_FULL_MARGIN  = 16,
  parameter int unsigned ALMOST_EMPTY_THRESH = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [31:0]           wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  input  logic                  clear_overflow,
  input  logic                  rd_en,
  output logic [63:0]           rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  half_pending,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   C_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   C_AF   = (DEPTH_LOG2 + 1)'(DEPTH - ALMOST_FULL_MARGIN);
  localparam logic [DEPTH_LOG2:0]   C_AE   = (DEPTH_LOG2 + 1)'(ALMOST_EMPTY_THRESH);
  localparam logic [DEPTH_LOG2:0]   C_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] P_ONE  = (DEPTH_LOG2)'(1);

  logic [63:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic [31:0]           r_hold;
  logic                  r_half;
  logic                  r_ovf;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_full;
  logic                  r_afull;
  logic                  w_pop;
  logic                  w_commit;
  logic                  w_push;
  logic                  w_drop;

  // Pop/commit arbitration; a pop in the same cycle frees room for a commit.
  always_comb begin
    w_pop       = 1'b0;
    w_commit    = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      w_pop    = rd_en & ~r_empty;
      w_commit = wr_en & r_half;
      w_push   = w_commit & (~r_full | w_pop);
      w_drop   = w_commit & r_full & ~w_pop;
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + C_ONE;
        2'b01:   w_count_nxt = r_count - C_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointers, packing state, sticky overflow and status flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_hold   <= 32'h0000_0000;
      r_half   <= 1'b0;
      r_ovf    <= 1'b0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_half <= 1'b0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + P_ONE;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + P_ONE;
        end
        if (wr_en) begin
          r_half <= ~r_half;
          if (!r_half) begin
            r_hold <= wr_data;
          end
        end
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clear_overflow) begin
        r_ovf <= 1'b0;
      end
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_aempty <= (w_count_nxt <= C_AE);
      r_full   <= (w_count_nxt == C_FULL);
      r_afull  <= (w_count_nxt >= C_AF);
    end
  end

  // Entry storage: first-written word lands in the upper half.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_hold, wr_data};
    end
  end

  assign rd_data      = r_mem[r_rptr];
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign full         = r_full;
  assign almost_full  = r_afull;
  assign half_pending = r_half;
  assign count        = r_count;
  assign overflow     = r_ovf;

endmodule
